dbus_arbiter: RTL

- Shares the single data-side bus (DM, TC0, TC1, interrupt-generator register) between two requesters: M0, the CPU MEM stage (addr/byteen/wdata already produced by the store byte-enable logic), and M1, a DMA/debug master.
- Arbitration is round-robin, with an optional bounded lock for M1 bursts.
- Decodes the granted address into per-slave strobes and returns registered read data or an error one cycle after the grant.
- Sits between the MEM stage and the slave devices; m0 stall is fed back to the pipeline hazard unit.

---
 rtl/dbus_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
// Shares the data-side bus (DM, TC0, TC1, interrupt-generator register)
// between the CPU MEM stage (M0) and a DMA/debug master (M1).
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   m0_* (req/addr/we/byteen/wdata in; gnt/stall/rvalid/rdata/err out)
//                           CPU MEM-stage master
//   m1_* (same set plus m1_lock in)
//                           DMA/debug master, may lock the bus for bursts
//   s_addr, s_wdata         address/data of the granted access (0 when idle)
//   dm_byteen               DM byte write enables
//   tc0_we, tc1_we, ins_we  word write strobes for timers and INS register
//   dm/tc0/tc1/ins_rdata    slave read data, valid the cycle after access
// ---------------------------------------------------------------------------
module dbus_arbiter #(
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_stall,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_byteen,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  dm_byteen,
  output logic        tc0_we,
  output logic        tc1_we,
  output logic        ins_we,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic [31:0] ins_rdata
);

  localparam logic ST_ARB   = 1'b0;
  localparam logic ST_LOCK1 = 1'b1;

  localparam logic [2:0] REG_MISS = 3'd0;
  localparam logic [2:0] REG_DM   = 3'd1;
  localparam logic [2:0] REG_TC0  = 3'd2;
  localparam logic [2:0] REG_TC1  = 3'd3;
  localparam logic [2:0] REG_INS  = 3'd4;

  // Count value at which the next locked grant would be the last one allowed.
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

  logic             r_state;
  logic [CNT_W-1:0] r_lockCnt;
  logic             r_lastOwner;   // 0 = M0, 1 = M1
  logic             r_rvalid0;
  logic             r_rvalid1;
  logic [2:0]       r_region;
  logic             r_err;
  logic             r_load;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_we;
  logic [3:0]  w_byteen;
  logic [2:0]  w_region;
  logic        w_fullWord;
  logic        w_err;
  logic        w_wr;
  logic [31:0] w_slaveData;
  logic [31:0] w_respData;

  // Grant selection. While M1 holds the lock it is the only candidate;
  // otherwise a tie goes to whoever did not own the bus last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == ST_LOCK1) begin
      w_gnt1 = m1_req;
    end else if (m0_req && m1_req) begin
      w_gnt0 = r_lastOwner;
      w_gnt1 = ~r_lastOwner;
    end else begin
      w_gnt0 = m0_req;
      w_gnt1 = m1_req;
    end
  end

  assign w_any = w_gnt0 | w_gnt1;

  // Route the granted master's request onto the slave side; everything is
  // zero when nobody is granted so idle cycles never look like accesses.
  always_comb begin
    w_addr   = 32'h0;
    w_wdata  = 32'h0;
    w_we     = 1'b0;
    w_byteen = 4'h0;
    if (w_gnt0) begin
      w_addr   = m0_addr;
      w_wdata  = m0_wdata;
      w_we     = m0_we;
      w_byteen = m0_byteen;
    end else if (w_gnt1) begin
      w_addr   = m1_addr;
      w_wdata  = m1_wdata;
      w_we     = m1_we;
      w_byteen = m1_byteen;
    end
  end

  // Address decode of the granted access.
  always_comb begin
    w_region = REG_MISS;
    if (w_addr <= 32'h0000_2FFF)
      w_region = REG_DM;
    else if (w_addr >= 32'h0000_7F00 && w_addr <= 32'h0000_7F0B)
      w_region = REG_TC0;
    else if (w_addr >= 32'h0000_7F10 && w_addr <= 32'h0000_7F1B)
      w_region = REG_TC1;
    else if (w_addr >= 32'h0000_7F20 && w_addr <= 32'h0000_7F23)
      w_region = REG_INS;
  end

  // Timer and INS registers only accept whole-word stores; a partial store
  // there is rejected with an error instead of corrupting the register.
  assign w_fullWord = (w_byteen == 4'hF);
  assign w_err      = (w_region == REG_MISS) ||
                      (w_we && (w_region != REG_DM) && !w_fullWord);
  assign w_wr       = w_any && w_we;

  assign s_addr    = w_addr;
  assign s_wdata   = w_wdata;
  assign dm_byteen = (w_wr && w_region == REG_DM) ? w_byteen : 4'h0;
  assign tc0_we    = w_wr && (w_region == REG_TC0) && w_fullWord;
  assign tc1_we    = w_wr && (w_region == REG_TC1) && w_fullWord;
  assign ins_we    = w_wr && (w_region == REG_INS) && w_fullWord;

  assign m0_gnt   = w_gnt0;
  assign m1_gnt   = w_gnt1;
  assign m0_stall = m0_req & ~w_gnt0;

  // Arbitration state: lock entry/exit and round-robin history. A burst
  // counts its first grant in ARB, so leaving at LOCK_LAST caps it at
  // MAX_LOCK grants and leaves last_owner at M1 so M0 wins next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_ARB;
      r_lockCnt   <= '0;
      r_lastOwner <= 1'b1;
    end else begin
      if (w_gnt0)
        r_lastOwner <= 1'b0;
      else if (w_gnt1)
        r_lastOwner <= 1'b1;

      if (r_state == ST_ARB) begin
        if (w_gnt1 && m1_lock && (MAX_LOCK > 1)) begin
          r_state   <= ST_LOCK1;
          r_lockCnt <= CNT_W'(1);
        end
      end else begin
        if (m1_req && m1_lock && (r_lockCnt < LOCK_LAST)) begin
          r_lockCnt <= r_lockCnt + CNT_W'(1);
        end else begin
          r_state   <= ST_ARB;
          r_lockCnt <= '0;
        end
      end
    end
  end

  // Response bookkeeping: remember who was served and what kind of access
  // it was, so the reply can be formed from slave data one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_region  <= REG_MISS;
      r_err     <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0;
      r_rvalid1 <= w_gnt1;
      r_region  <= w_region;
      r_err     <= w_err;
      r_load    <= ~w_we;
    end
  end

  // Read data mux on the registered region; stores and errors return zero.
  always_comb begin
    w_slaveData = 32'h0;
    case (r_region)
      REG_DM:  w_slaveData = dm_rdata;
      REG_TC0: w_slaveData = tc0_rdata;
      REG_TC1: w_slaveData = tc1_rdata;
      REG_INS: w_slaveData = ins_rdata;
      default: w_slaveData = 32'h0;
    endcase
  end

  assign w_respData = (r_load && !r_err) ? w_slaveData : 32'h0;

  assign m0_rvalid = r_rvalid0;
  assign m0_rdata  = r_rvalid0 ? w_respData : 32'h0;
  assign m0_err    = r_rvalid0 & r_err;
  assign m1_rvalid = r_rvalid1;
  assign m1_rdata  = r_rvalid1 ? w_respData : 32'h0;
  assign m1_err    = r_rvalid1 & r_err;

endmodule
